// File: rtl/data_mem_ctrl.sv
// Byte-addressed data memory controller for the MEM stage: byte/half/word stores with lane enables,
// sign/zero-extended loads with one-cycle registered response, misalignment errors, post-reset clear.
module data_mem_ctrl #(
    parameter int DEPTH          = 256,
    parameter int ADDR_W         = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              rvalid,
    output logic              err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    logic [31:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              req_ready_q, req_ready_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [31:0]       data_out_q, data_out_d;

    logic [IDX_W-1:0]  req_idx;
    logic [1:0]        lane;
    logic              accept, bad_req;
    logic [31:0]       rd_word, shifted, load_val;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              unused_addr;

    assign unused_addr = ^addr;
    assign req_idx     = addr[IDX_W+1:2];
    assign lane        = addr[1:0];

    // Handshake: a request transfers on a rising edge where req_valid & req_ready & (wr | rd);
    // req_ready is 1 throughout RUN, so there is never back-pressure once the clear is done.
    assign accept  = (state_q == ST_RUN) && req_ready_q && req_valid && (wr || rd);
    assign bad_req = (size == 2'b11) || ((size == 2'b01) && addr[0]) ||
                     ((size == 2'b10) && (addr[1:0] != 2'b00)) || (wr && rd);

    always_comb begin
        rd_word  = mem[req_idx];
        shifted  = rd_word >> {lane, 3'b000};
        load_val = shifted;
        case (size)
            2'b00:   load_val = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // The clear sequencer and stores share one write port; they never overlap by state.
    always_comb begin
        mem_we    = 1'b0;
        mem_idx   = req_idx;
        mem_be    = 4'b0000;
        mem_wdata = data_in;
        if (state_q == ST_CLEAR) begin
            mem_we    = CLEAR_ON_RESET;
            mem_idx   = cnt_q;
            mem_be    = 4'b1111;
            mem_wdata = 32'h0;
        end else if (accept && wr && !bad_req) begin
            mem_we = 1'b1;
            case (size)
                2'b00: begin
                    mem_be    = 4'b0001 << lane;
                    mem_wdata = {4{data_in[7:0]}};
                end
                2'b01: begin
                    mem_be    = addr[1] ? 4'b1100 : 4'b0011;
                    mem_wdata = {2{data_in[15:0]}};
                end
                default: begin
                    mem_be    = 4'b1111;
                    mem_wdata = data_in;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_be[b]) mem[mem_idx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        req_ready_d = req_ready_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        data_out_d  = data_out_q;
        case (state_q)
            ST_CLEAR: begin
                if (!CLEAR_ON_RESET || (cnt_q == LAST_IDX)) begin
                    state_d     = ST_RUN;
                    busy_d      = 1'b0;
                    req_ready_d = 1'b1;
                end
                if (CLEAR_ON_RESET) cnt_d = cnt_q + 1'b1;
            end
            default: begin
                if (accept) begin
                    if (bad_req) begin
                        rvalid_d   = 1'b1;
                        err_d      = 1'b1;
                        data_out_d = 32'h0;
                    end else if (rd) begin
                        rvalid_d   = 1'b1;
                        data_out_d = load_val;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            cnt_q       <= '0;
            busy_q      <= CLEAR_ON_RESET;
            req_ready_q <= 1'b0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            data_out_q  <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            req_ready_q <= req_ready_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            data_out_q  <= data_out_d;
        end
    end

    assign req_ready = req_ready_q;
    assign busy      = busy_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign data_out  = data_out_q;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: driver tasks push expected {err,data} responses, a negedge
// monitor pops and compares them whenever rvalid is seen.
module tb_data_mem_ctrl;
    localparam int W = 33;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, wr, rd, sign_ext;
    logic        req_ready, rvalid, err, busy;
    logic [31:0] addr, data_in, data_out;
    logic [1:0]  size;

    logic [W-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    data_mem_ctrl #(.DEPTH(256), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .wr(wr), .rd(rd), .addr(addr), .size(size), .sign_ext(sign_ext),
        .data_in(data_in), .data_out(data_out), .rvalid(rvalid), .err(err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rvalid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rsp: got err=%b data=%h expected no response", err, data_out);
            end else begin
                e = exp_q.pop_front();
                if ({err, data_out} !== e) begin
                    failures++;
                    $display("FAIL rsp: got err=%b data=%h expected err=%b data=%h",
                             err, data_out, e[32], e[31:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input logic w, input logic r, input logic [31:0] a, input logic [1:0] sz,
                         input logic se, input logic [31:0] d, input logic rsp, input logic [W-1:0] e);
        req_valid = 1'b1; wr = w; rd = r; addr = a; size = sz; sign_ext = se; data_in = d;
        if (rsp) exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic se, input logic [31:0] e);
        issue(1'b0, 1'b1, a, sz, se, 32'h0, 1'b1, {1'b0, e});
    endtask

    task automatic st(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        issue(1'b1, 1'b0, a, sz, 1'b0, d, 1'b0, '0);
    endtask

    task automatic bad(input logic w, input logic r, input logic [31:0] a, input logic [1:0] sz,
                       input logic [31:0] d);
        issue(w, r, a, sz, 1'b0, d, 1'b1, {1'b1, 32'h0});
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (req_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1;
            n++;
            if (n == 128) begin
                check({name, "_busy_mid"}, {31'h0, busy}, 32'h1);
                check({name, "_ready_mid"}, {31'h0, req_ready}, 32'h0);
            end
        end
        check({name, "_clear_cycles"}, n, 32'd256);
        check({name, "_busy_done"}, {31'h0, busy}, 32'h0);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = '0; size = 2'b10; sign_ext = 1'b0; data_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_rvalid", {31'h0, rvalid}, 32'h0);
        check("rst_err", {31'h0, err}, 32'h0);
        check("rst_data", data_out, 32'h0);

        // a load held during the clear must be ignored
        @(negedge clk) reset = 1'b1;
        req_valid = 1'b1; rd = 1'b1; addr = 32'h0; size = 2'b10;
        wait_clear("init");
        req_valid = 1'b0; rd = 1'b0;

        ld(32'h3FC, 2'b10, 1'b0, 32'h0000_0000);

        st(32'h10, 2'b10, 32'h8000_0001);
        ld(32'h13, 2'b00, 1'b1, 32'hFFFF_FF80);
        ld(32'h13, 2'b00, 1'b0, 32'h0000_0080);
        ld(32'h10, 2'b01, 1'b0, 32'h0000_0001);
        ld(32'h12, 2'b01, 1'b1, 32'hFFFF_8000);
        ld(32'h12, 2'b01, 1'b0, 32'h0000_8000);

        st(32'h21, 2'b00, 32'hFFFF_FFAB);
        ld(32'h20, 2'b10, 1'b0, 32'h0000_AB00);
        st(32'h22, 2'b01, 32'hFFFF_1234);
        ld(32'h20, 2'b10, 1'b0, 32'h1234_AB00);
        ld(32'h22, 2'b01, 1'b1, 32'h0000_1234);
        ld(32'h21, 2'b00, 1'b1, 32'hFFFF_FFAB);

        bad(1'b0, 1'b1, 32'h05, 2'b01, 32'h0);
        bad(1'b1, 1'b0, 32'h06, 2'b10, 32'h5555_5555);
        bad(1'b1, 1'b0, 32'h08, 2'b11, 32'hDEAD_BEEF);
        bad(1'b1, 1'b1, 32'h20, 2'b10, 32'hFFFF_FFFF);
        ld(32'h04, 2'b10, 1'b0, 32'h0000_0000);
        ld(32'h08, 2'b10, 1'b0, 32'h0000_0000);
        ld(32'h20, 2'b10, 1'b0, 32'h1234_AB00);

        // no-op and unqualified requests produce no response
        issue(1'b0, 1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 1'b0, '0);
        req_valid = 1'b0; rd = 1'b1; addr = 32'h10;
        @(posedge clk); #1;
        rd = 1'b0;

        st(32'h400, 2'b10, 32'hCAFE_F00D);
        ld(32'h000, 2'b10, 1'b0, 32'hCAFE_F00D);
        idle(3);
        check("data_hold", data_out, 32'hCAFE_F00D);
        check("rvalid_pulse", {31'h0, rvalid}, 32'h0);

        // a load accepted just before reset must not respond
        req_valid = 1'b1; rd = 1'b1; addr = 32'h10; size = 2'b10;
        @(posedge clk); #1;
        reset = 1'b0; req_valid = 1'b0; rd = 1'b0;
        #1;
        check("drop_rvalid", {31'h0, rvalid}, 32'h0);
        check("drop_data", data_out, 32'h0);
        @(negedge clk) reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midclr_busy", {31'h0, busy}, 32'h1);
        check("midclr_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk) reset = 1'b1;
        wait_clear("restart");

        ld(32'h10, 2'b10, 1'b0, 32'h0000_0000);
        ld(32'h000, 2'b10, 1'b0, 32'h0000_0000);
        idle(4);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised successor of the single-cycle data memory for the MEM stage of the pipelined core.
- Byte-addressed, synchronous, with a one-cycle registered read and a valid/ready request handshake.
- Supports byte/half/word accesses with byte-lane writes, sign/zero-extended loads, and misalignment detection.
- Array clear is a hardware sequencer run after reset, not a single-cycle bulk clear.

Parameters:
- DEPTH, 256, number of 32-bit words; power of two, >= 4.
- ADDR_W, 32, byte-address width; must be >= log2(DEPTH)+2.
- CLEAR_ON_RESET, 1: 1 = sequencer zeroes every word after reset; 0 = array contents left undefined, ready one cycle after reset release.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  controller can accept a request.
- wr  in  1  store request (qualified by req_valid).
- rd  in  1  load request (qualified by req_valid).
- addr  in  ADDR_W  byte address.
- size  in  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- sign_ext  in  1  loads only: 1 sign-extend, 0 zero-extend.
- data_in  in  32  store data, right-aligned.
- data_out  out  32  load data, right-aligned and extended.
- rvalid  out  1  one-cycle pulse marking a load response or an error response.
- err  out  1  valid with rvalid: request was misaligned or illegal.
- busy  out  1  clear sequencer active.

Behaviour:
- Reset (reset=0, asynchronous)
  - Outputs: req_ready=0, rvalid=0, err=0, data_out=0, busy=CLEAR_ON_RESET.
  - Clear counter=0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, otherwise RUN on the first edge after release.
- Reset mid-operation
  - A clear in progress is aborted and restarts from word 0.
  - A pending response is dropped.
  - Array contents are not guaranteed to be preserved.
- FSM states: CLEAR, RUN.
- CLEAR
  - Each cycle writes 0 to mem[cnt], then cnt <= cnt+1.
  - After the cycle that writes word DEPTH-1: busy=0, move to RUN, req_ready=1 from the next cycle.
  - The clear takes exactly DEPTH cycles after reset release.
  - Requests presented during CLEAR are ignored; req_ready=0 throughout.
- RUN
  - req_ready=1 every cycle: no back-pressure, one request accepted per cycle.
  - Accept = req_valid & req_ready & (wr | rd).
  - req_valid with wr=rd=0 is a no-op: no response.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4 bytes.
- Lane = addr[1:0]. A request is misaligned if:
  - size=01 and addr[0]=1; or
  - size=10 and addr[1:0]!=0; or
  - size=11.
- wr=1 and rd=1 together is illegal.
- Store (wr=1, legal)
  - byte: data_in[7:0] written to lane addr[1:0].
  - half: data_in[15:0] written to lanes addr[1]*2 and addr[1]*2+1.
  - word: all 4 lanes written.
  - Other lanes unchanged. No response; rvalid stays 0.
- Load (rd=1, legal)
  - Array read at the acceptance edge; the next cycle has rvalid=1, err=0, data_out = selected bytes shifted to bit 0.
  - Bits above the access width are filled with the access MSB if sign_ext=1, else 0.
  - Latency is exactly 1 cycle.
- Error (misaligned or illegal request)
  - No array write.
  - Next cycle: rvalid=1, err=1, data_out=0. Applies to stores as well as loads.
- data_out holds its last response value until the next response; rvalid and err are single-cycle pulses.
- Store in cycle N followed by a load of the same word in cycle N+1 returns the new data. No forwarding path is needed because the array is updated at the store's edge.
- Back-to-back loads produce back-to-back rvalid pulses, in order.

Test Plan:
- CLEAR_ON_RESET=1, DEPTH=256: release reset -> busy=1 and req_ready=0 for 256 cycles, then req_ready=1; a word load from 0x3FC returns 0x00000000.
- Word store 0x80000001 @0x10, then in consecutive cycles: byte load @0x13 with sign_ext=1 -> 0xFFFFFF80; byte load @0x13 with sign_ext=0 -> 0x00000080; half load @0x10 -> 0x00000001.
- Byte store 0xAB @0x21, then word load @0x20 -> 0x0000AB00; half store 0x1234 @0x22, then word load @0x20 -> 0x1234AB00.
- Half load @0x05, word store @0x06, size=11 request, wr=rd=1 request -> each gives rvalid=1, err=1, data_out=0 one cycle later; memory unchanged, verified by readback.
- DEPTH=256: word store 0xCAFEF00D @0x400 -> word load @0x000 returns 0xCAFEF00D (address wrap).
- Assert reset at clear cycle 100, release -> clear restarts and busy lasts a full 256 cycles; a pending load response is suppressed (rvalid stays 0).
